// File: rtl/inst_fetch_if.sv
// Fetch-side bundle: RAM read port, IF/ID presentation and EX redirect.
interface inst_fetch_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_busy_in;
  logic [7:0]            mem_data_in;
  logic                  mem_req_out;
  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic                  stall_in;
  logic                  jump_in;
  logic [ADDR_WIDTH-1:0] jump_target_in;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic [31:0]           inst_out;
  logic                  inst_valid_out;

  // Fetch unit side
  modport master (
    input  mem_busy_in, mem_data_in, stall_in, jump_in, jump_target_in,
    output mem_req_out, mem_addr_out, pc_out, inst_out, inst_valid_out
  );

  // RAM / pipeline side
  modport slave (
    output mem_busy_in, mem_data_in, stall_in, jump_in, jump_target_in,
    input  mem_req_out, mem_addr_out, pc_out, inst_out, inst_valid_out
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: assembles a 32-bit little-endian instruction from four
// byte reads on the shared RAM port and presents it to the IF/ID register.
//
// state | meaning
// B0    | request byte 0 (pc)
// B1    | request byte 1, capture byte 0
// B2    | request byte 2, capture byte 1
// B3    | request byte 3, capture byte 2
// B4    | capture byte 3, register instruction
// OUT   | instruction presented, wait for IF/ID to accept
module inst_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic          clk_in,
  input  logic          rst_in,
  inst_fetch_if.master  bus
);

  typedef enum logic [2:0] {B0, B1, B2, B3, B4, OUT} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [23:0]           byte_buf;
  logic                  fetching;
  logic                  req;
  logic [ADDR_WIDTH-1:0] byte_off;

  assign fetching = (state == B0) || (state == B1) || (state == B2) || (state == B3);

  // Reset gates the request so nothing is issued while the unit is held in reset.
  assign req = rst_in && fetching && !bus.mem_busy_in;

  // Byte offset of the request issued in the current state.
  always_comb begin
    byte_off = '0;
    case (state)
      B1:      byte_off = ADDR_WIDTH'(1);
      B2:      byte_off = ADDR_WIDTH'(2);
      B3:      byte_off = ADDR_WIDTH'(3);
      default: byte_off = '0;
    endcase
  end

  assign bus.mem_req_out  = req;
  assign bus.mem_addr_out = req ? (pc + byte_off) : '0;

  // Fetch sequencing, byte capture and registered presentation outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state              <= B0;
      pc                 <= RESET_PC;
      byte_buf           <= '0;
      bus.pc_out         <= RESET_PC;
      bus.inst_out       <= '0;
      bus.inst_valid_out <= 1'b0;
    end else if (bus.jump_in) begin
      // Redirect wins over everything; an in-flight byte is simply never captured.
      state              <= B0;
      pc                 <= bus.jump_target_in;
      byte_buf           <= '0;
      bus.inst_valid_out <= 1'b0;
    end else begin
      case (state)
        B0: begin
          state <= bus.mem_busy_in ? B0 : B1;
        end
        B1: begin
          if (bus.mem_busy_in) begin
            state    <= B0;
            byte_buf <= '0;
          end else begin
            byte_buf[7:0] <= bus.mem_data_in;
            state         <= B2;
          end
        end
        B2: begin
          if (bus.mem_busy_in) begin
            state    <= B0;
            byte_buf <= '0;
          end else begin
            byte_buf[15:8] <= bus.mem_data_in;
            state          <= B3;
          end
        end
        B3: begin
          if (bus.mem_busy_in) begin
            state    <= B0;
            byte_buf <= '0;
          end else begin
            byte_buf[23:16] <= bus.mem_data_in;
            state           <= B4;
          end
        end
        B4: begin
          // Byte 3 was already issued, so a busy MEM stage no longer matters.
          bus.inst_out       <= {bus.mem_data_in, byte_buf};
          bus.pc_out         <= pc;
          bus.inst_valid_out <= 1'b1;
          state              <= OUT;
        end
        OUT: begin
          if (!bus.stall_in) begin
            pc                 <= pc + ADDR_WIDTH'(4);
            bus.inst_valid_out <= 1'b0;
            state              <= B0;
          end
        end
        default: begin
          state <= B0;
        end
      endcase
    end
  end

endmodule
